// File: rtl/aes_inv_cipher.sv
// AES-128 iterative decryptor: one round per clock. Round keys are walked
// forward to rk10 and then unwound backward on the fly, so no key storage.
package aes_inv_pkg;
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // a^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] s;
    logic [7:0] r;
    s = a;
    r = 8'h01;
    for (int k = 1; k < 8; k++) begin
      s = gf_mul(s, s);
      r = gf_mul(r, s);
    end
    return r;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] idx);
    case (idx)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction
endpackage

module aes_sbox (
  input  logic [7:0] a_i,
  output logic [7:0] y_o
);
  import aes_inv_pkg::*;
  logic [7:0] b;
  assign b   = gf_inv(a_i);
  assign y_o = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
             ^ {b[3:0], b[7:4]} ^ 8'h63;
endmodule

module aes_inv_sbox (
  input  logic [7:0] a_i,
  output logic [7:0] y_o
);
  import aes_inv_pkg::*;
  logic [7:0] b;
  assign b   = {a_i[6:0], a_i[7]} ^ {a_i[4:0], a_i[7:5]} ^ {a_i[1:0], a_i[7:2]} ^ 8'h05;
  assign y_o = gf_inv(b);
endmodule

module aes_inv_mixcol (
  input  logic [31:0] col_i,
  output logic [31:0] col_o
);
  import aes_inv_pkg::*;
  logic [7:0] s0, s1, s2, s3;
  assign {s0, s1, s2, s3} = col_i;
  assign col_o[31:24] = gf_mul(8'h0e, s0) ^ gf_mul(8'h0b, s1) ^ gf_mul(8'h0d, s2) ^ gf_mul(8'h09, s3);
  assign col_o[23:16] = gf_mul(8'h09, s0) ^ gf_mul(8'h0e, s1) ^ gf_mul(8'h0b, s2) ^ gf_mul(8'h0d, s3);
  assign col_o[15:8]  = gf_mul(8'h0d, s0) ^ gf_mul(8'h09, s1) ^ gf_mul(8'h0e, s2) ^ gf_mul(8'h0b, s3);
  assign col_o[7:0]   = gf_mul(8'h0b, s0) ^ gf_mul(8'h0d, s1) ^ gf_mul(8'h09, s2) ^ gf_mul(8'h0e, s3);
endmodule

// state  | meaning
// IDLE   | waiting for start
// KEYEXP | expanding rk0 -> rk10, counter = round being produced
// DEC    | inverse rounds 9..0, counter = round key applied this edge
module aes_inv_cipher (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] inp_data,
  input  logic [127:0] inp_key,
  output logic         busy,
  output logic         done,
  output logic [127:0] out_data
);
  import aes_inv_pkg::*;

  typedef enum logic [1:0] {IDLE, KEYEXP, DEC} state_e;

  state_e       fsm_q;
  logic [3:0]   cnt_q;
  logic [127:0] data_q, key_q, out_q;
  logic         done_q;

  logic [31:0]  w0, w1, w2, w3, bw1, bw2, bw3, fw0, fw1, fw2, fw3;
  logic [31:0]  sub_in, sub_out;
  logic [3:0]   rc_idx;
  logic [127:0] key_fwd, key_bwd, sh, isb, ark, imc;

  assign {w0, w1, w2, w3} = key_q;
  assign rc_idx = (fsm_q == KEYEXP) ? cnt_q : cnt_q + 4'd1;
  assign bw3 = w3 ^ w2;
  assign bw2 = w2 ^ w1;
  assign bw1 = w1 ^ w0;
  // Both directions need SubWord(RotWord(.)) of a single word, so one set of S-boxes serves both
  assign sub_in = (fsm_q == KEYEXP) ? {w3[23:0], w3[31:24]} : {bw3[23:0], bw3[31:24]};
  assign fw0 = w0 ^ sub_out ^ {rcon(rc_idx), 24'h000000};
  assign fw1 = w1 ^ fw0;
  assign fw2 = w2 ^ fw1;
  assign fw3 = w3 ^ fw2;
  assign key_fwd = {fw0, fw1, fw2, fw3};
  assign key_bwd = {fw0, bw1, bw2, bw3};

  for (genvar i = 0; i < 4; i++) begin : g_ksbox
    aes_sbox u_sbox (.a_i(sub_in[31-8*i -: 8]), .y_o(sub_out[31-8*i -: 8]));
  end

  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign sh[127-8*(4*c+r) -: 8] = data_q[127-8*(4*((c+4-r)%4)+r) -: 8];
      aes_inv_sbox u_isbox (.a_i(sh[127-8*(4*c+r) -: 8]), .y_o(isb[127-8*(4*c+r) -: 8]));
    end
    aes_inv_mixcol u_imc (.col_i(ark[127-32*c -: 32]), .col_o(imc[127-32*c -: 32]));
  end

  assign ark = isb ^ key_bwd;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q  <= IDLE;
      cnt_q  <= 4'd0;
      data_q <= '0;
      key_q  <= '0;
      out_q  <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (fsm_q)
        IDLE: begin
          if (start) begin
            data_q <= inp_data;
            key_q  <= inp_key;
            cnt_q  <= 4'd1;
            fsm_q  <= KEYEXP;
          end
        end
        KEYEXP: begin
          key_q <= key_fwd;
          if (cnt_q == 4'd10) begin
            data_q <= data_q ^ key_fwd;
            cnt_q  <= 4'd9;
            fsm_q  <= DEC;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        DEC: begin
          key_q <= key_bwd;
          if (cnt_q == 4'd0) begin
            out_q  <= ark;
            done_q <= 1'b1;
            fsm_q  <= IDLE;
          end else begin
            data_q <= imc;
            cnt_q  <= cnt_q - 4'd1;
          end
        end
        default: fsm_q <= IDLE;
      endcase
    end
  end

  assign busy     = (fsm_q != IDLE);
  assign done     = done_q;
  assign out_data = out_q;
endmodule

// File: tb/tb_aes_inv_cipher.sv
// Directed bench for aes_inv_cipher using FIPS-197 vectors and the all-zero-key vector.
module tb_aes_inv_cipher;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [127:0] inp_data = '0;
  logic [127:0] inp_key = '0;
  logic         busy, done;
  logic [127:0] out_data;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [127:0] KA    = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CA    = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PA    = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KB    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CB    = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PB    = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] RK10B = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] CZ    = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  aes_inv_cipher dut (
    .clk(clk), .rst(rst), .start(start), .inp_data(inp_data), .inp_key(inp_key),
    .busy(busy), .done(done), .out_data(out_data)
  );

  always #5 clk = ~clk;

  task automatic launch(input logic [127:0] k, input logic [127:0] c);
    @(negedge clk);
    start = 1'b1; inp_key = k; inp_data = c;
    @(posedge clk); #1;
    start = 1'b0;
    inp_key = ~k; inp_data = ~c;
  endtask

  task automatic wait_done(output int cyc, output logic [127:0] k10);
    cyc = 0;
    k10 = '0;
    while (cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 10) k10 = dut.key_q;
      if (done) break;
    end
    if (!done) cyc = -1;
  endtask

  task automatic test_reset();
    #2;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
    n_cmp++; if (out_data !== 128'h0) begin n_err++; $display("FAIL reset_out: got %h want 0", out_data); end
    n_cmp++; if (dut.key_q !== 128'h0) begin n_err++; $display("FAIL reset_key: got %h want 0", dut.key_q); end
    n_cmp++; if (dut.cnt_q !== 4'd0) begin n_err++; $display("FAIL reset_cnt: got %0d want 0", dut.cnt_q); end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_vector_a();
    int cyc;
    logic [127:0] k10;
    launch(KA, CA);
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL a_busy_after_start: got %b want 1", busy); end
    wait_done(cyc, k10);
    n_cmp++; if (cyc !== 20) begin n_err++; $display("FAIL a_latency: got %0d want 20", cyc); end
    n_cmp++; if (out_data !== PA) begin n_err++; $display("FAIL a_plaintext: got %h want %h", out_data, PA); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL a_busy_at_done: got %b want 0", busy); end
    @(posedge clk); #1;
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL a_done_pulse_width: got %b want 0", done); end
    n_cmp++; if (out_data !== PA) begin n_err++; $display("FAIL a_out_hold: got %h want %h", out_data, PA); end
  endtask

  task automatic test_vector_b();
    int cyc;
    logic [127:0] k10;
    launch(KB, CB);
    wait_done(cyc, k10);
    n_cmp++; if (cyc !== 20) begin n_err++; $display("FAIL b_latency: got %0d want 20", cyc); end
    n_cmp++; if (k10 !== RK10B) begin n_err++; $display("FAIL b_rk10: got %h want %h", k10, RK10B); end
    n_cmp++; if (dut.key_q !== KB) begin n_err++; $display("FAIL b_rk0_restored: got %h want %h", dut.key_q, KB); end
    n_cmp++; if (out_data !== PB) begin n_err++; $display("FAIL b_plaintext: got %h want %h", out_data, PB); end
  endtask

  task automatic test_zero_key();
    int cyc;
    logic [127:0] k10;
    launch(128'h0, CZ);
    wait_done(cyc, k10);
    n_cmp++; if (cyc !== 20) begin n_err++; $display("FAIL z_latency: got %0d want 20", cyc); end
    n_cmp++; if (out_data !== 128'h0) begin n_err++; $display("FAIL z_plaintext: got %h want 0", out_data); end
  endtask

  task automatic test_start_while_busy();
    int dones = 0;
    int first_done = 0;
    logic busy_ok = 1'b1;
    launch(KA, CA);
    for (int i = 1; i <= 25; i++) begin
      @(negedge clk);
      start = (i == 5);
      inp_key = KB; inp_data = CB;
      @(posedge clk); #1;
      if (done) begin
        dones++;
        if (first_done == 0) first_done = i;
      end
      if (i < 20 && busy !== 1'b1) busy_ok = 1'b0;
    end
    n_cmp++; if (dones !== 1) begin n_err++; $display("FAIL busy_ign_done_count: got %0d want 1", dones); end
    n_cmp++; if (first_done !== 20) begin n_err++; $display("FAIL busy_ign_latency: got %0d want 20", first_done); end
    n_cmp++; if (busy_ok !== 1'b1) begin n_err++; $display("FAIL busy_ign_busy_held: got %b want 1", busy_ok); end
    n_cmp++; if (out_data !== PA) begin n_err++; $display("FAIL busy_ign_plaintext: got %h want %h", out_data, PA); end
  endtask

  task automatic test_reset_mid();
    int cyc;
    int nd = 0;
    logic [127:0] k10;
    launch(KA, CA);
    repeat (12) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rmid_busy: got %b want 0", busy); end
    n_cmp++; if (out_data !== 128'h0) begin n_err++; $display("FAIL rmid_out: got %h want 0", out_data); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL rmid_done: got %b want 0", done); end
    @(posedge clk);
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      if (done) nd++;
    end
    n_cmp++; if (nd !== 0) begin n_err++; $display("FAIL rmid_no_done: got %0d want 0", nd); end
    launch(KB, CB);
    wait_done(cyc, k10);
    n_cmp++; if (cyc !== 20) begin n_err++; $display("FAIL rmid_restart_latency: got %0d want 20", cyc); end
    n_cmp++; if (out_data !== PB) begin n_err++; $display("FAIL rmid_restart_plaintext: got %h want %h", out_data, PB); end
  endtask

  task automatic test_back_to_back();
    logic [127:0] keys [2];
    logic [127:0] cts  [2];
    logic [127:0] pts  [2];
    int cyc;
    logic stable;
    keys[0] = KA; cts[0] = CA; pts[0] = PA;
    keys[1] = KB; cts[1] = CB; pts[1] = PB;
    @(negedge clk);
    start = 1'b1; inp_key = keys[0]; inp_data = cts[0];
    @(posedge clk); #1;
    inp_key = keys[1]; inp_data = cts[1];
    for (int k = 0; k < 4; k++) begin
      cyc = 0;
      stable = 1'b1;
      while (cyc < 40) begin
        @(posedge clk); #1;
        cyc++;
        if (k > 0 && cyc == 1) begin
          inp_key = keys[(k+1)%2]; inp_data = cts[(k+1)%2];
        end
        if (done) break;
        if (k > 0 && out_data !== pts[(k-1)%2]) stable = 1'b0;
      end
      if (!done) cyc = -1;
      n_cmp++; if (cyc !== ((k == 0) ? 20 : 21)) begin n_err++; $display("FAIL b2b_period[%0d]: got %0d want %0d", k, cyc, (k == 0) ? 20 : 21); end
      n_cmp++; if (out_data !== pts[k%2]) begin n_err++; $display("FAIL b2b_plaintext[%0d]: got %h want %h", k, out_data, pts[k%2]); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL b2b_busy_at_done[%0d]: got %b want 0", k, busy); end
      if (k > 0) begin
        n_cmp++; if (stable !== 1'b1) begin n_err++; $display("FAIL b2b_out_stable[%0d]: got %b want 1", k, stable); end
      end
    end
    @(negedge clk); start = 1'b0;
    repeat (25) @(posedge clk);
  endtask

  initial begin
    test_reset();
    test_vector_a();
    test_vector_b();
    test_zero_key();
    test_start_while_busy();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/aes_inv_cipher.md
AES_INV_CIPHER -- requirements
Module: aes_inv_cipher

Interface
REQ-001 SHALL declare clock and reset first: clk input 1, rising-edge clock; rst input 1, asynchronous, active-high reset.
REQ-002 SHALL have start input 1: request a decryption; sampled only in IDLE.
REQ-003 SHALL have inp_data input 128: ciphertext block; byte 0 = [127:120], column-major state order per FIPS-197.
REQ-004 SHALL have inp_key input 128: AES-128 cipher key (round-0 key), same byte order.
REQ-005 SHALL have busy output 1: high while a block is in progress.
REQ-006 SHALL have done output 1: one-cycle pulse when out_data becomes valid.
REQ-007 SHALL have out_data output 128: recovered plaintext, registered, held until the next accepted start.

Function
REQ-008 SHALL implement FSM states IDLE, KEYEXP, DEC; one AES round operation per clock.
REQ-009 IDLE and start=1 at edge E0 -> latch inp_data and inp_key, round counter=1, busy=1, go to KEYEXP; inputs are ignored after E0.
REQ-010 KEYEXP, edges E1..E10: key register <= forward expansion of round key i-1 -> i (i=1..10), Rcon = 01,02,04,08,10,20,40,80,1b,36.
REQ-011 At E10, state register <= ciphertext XOR rk10 (combinational next key), counter=9, go to DEC.
REQ-012 DEC, edges E11..E19 (r=9..1): state <= InvMixColumns(InvSubBytes(InvShiftRows(state)) XOR rk_r).
REQ-013 DEC, edge E20 (r=0): out_data <= InvSubBytes(InvShiftRows(state)) XOR rk0; done=1 for that cycle; busy=0; go to IDLE.
REQ-014 Round keys SHALL be regenerated backward on the fly with no key storage. With w0..w3 = rk_i (w0 = [127:96]): w3'=w3^w2, w2'=w2^w1, w1'=w1^w0, w0'=w0^SubWord(RotWord(w3'))^{Rcon_i,000000}.
REQ-015 Latency SHALL be fixed: done asserted in the cycle following E20, i.e. 20 clocks after the start-sampling edge, independent of data.
REQ-016 start while busy=1 SHALL be ignored, with no queuing and no corruption of the block in flight.
REQ-017 start held high in the cycle done is high SHALL be accepted (back-to-back): next block begins at the edge where done falls; throughput 1 block per 21 clocks.
REQ-018 Inverse S-box, forward S-box (key schedule) and InvMixColumns (GF(2^8), poly 0x11b, coefficients 0e,0b,0d,09) SHALL be combinational submodules; the only sequential elements are FSM, 4-bit counter, 128-bit state, 128-bit key and out_data registers.
REQ-019 InvShiftRows SHALL rotate row n right by n bytes (n=0..3).
REQ-020 busy SHALL equal (FSM != IDLE); done SHALL never be high while busy=1.

Reset
REQ-021 rst=1 SHALL immediately force IDLE, counter=0, busy=0, done=0, out_data=0, internal state/key registers=0.
REQ-022 Reset mid-operation SHALL abandon the block; no done pulse; first start after rst deassertion SHALL be processed normally.

Verification
REQ-023 Key 000102030405060708090a0b0c0d0e0f, ct 69c4e0d86a7b0430d8cdb78070b4c55a, start at E0 -> done at E0+20, out_data=00112233445566778899aabbccddeeff.
REQ-024 Key 2b7e151628aed2a6abf7158809cf4f3c, ct 3925841d02dc09fbdc118597196a0b32 -> out_data=3243f6a8885a308d313198a2e0370734; internal key at E10 = d014f9a8c9ee2589e13f0cc8b6630ca6, at E20 = inp_key.
REQ-025 Start REQ-023 block, pulse start with the REQ-024 vector at E5 -> REQ-023 plaintext only, single done pulse, busy stays 1 throughout.
REQ-026 Assert rst at E12 of a block -> busy=0, out_data=0 asynchronously, no done; restart with REQ-024 vector -> correct plaintext after 20 clocks.
REQ-027 start held high continuously with alternating REQ-023/REQ-024 vectors -> done every 21 clocks, each out_data correct and stable until the following done.
REQ-028 Random-key/random-ct regression against a software AES-128 model (encrypt random pt, feed ct) -> 1000 blocks, zero mismatches.
